// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer; 4 cycles per ALU op, 5 per memory op at zero wait.
// Waits on if_ack/mem_ack with a watchdog (TIMEOUT, 0 = off); optional perf counters under NPC_PERF_CNT_EN.
module npc_ctrl_fsm #(
    parameter int CNT_WIDTH = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 if_ack,
    input  logic                 is_ebreak,
    input  logic                 is_illegal,
    input  logic                 is_mem,
    input  logic                 d_regW,
    input  logic                 mem_ack,
    output logic                 if_req,
    output logic                 inst_we,
    output logic                 mem_req,
    output logic                 w_regW,
    output logic                 pc_we,
    output logic                 halt,
    output logic                 err,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // A zero TIMEOUT would give a zero-width watchdog; keep one idle bit instead.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W:0] TO_LIM = (WD_W + 1)'(TIMEOUT);

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [WD_W:0]   wd_inc;
    logic            wd_hit;

    assign wd_inc = {1'b0, wd_q} + (WD_W + 1)'(1);
    assign wd_hit = (TIMEOUT != 0) && (wd_inc == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        if_req  = 1'b0;
        inst_we = 1'b0;
        mem_req = 1'b0;
        w_regW  = 1'b0;
        pc_we   = 1'b0;
        halt    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if_req  = 1'b1;
                inst_we = if_ack;
                if (if_ack)                state_d = S_DECODE;
                else if (wd_hit)           state_d = S_ERR;
                else if (TIMEOUT != 0)     wd_d    = wd_inc[WD_W-1:0];
            end
            S_DECODE: begin
                if (is_illegal)            state_d = S_ERR;
                else if (is_ebreak)        state_d = S_HALT;
                else                       state_d = S_EXEC;
            end
            S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack)               state_d = S_WB;
                else if (wd_hit)           state_d = S_ERR;
                else if (TIMEOUT != 0)     wd_d    = wd_inc[WD_W-1:0];
            end
            S_WB: begin
                w_regW  = d_regW;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:   halt = 1'b1;
            S_ERR:    err  = 1'b1;
            default:  state_d = S_IDLE;
        endcase
        // Every wait window starts its watchdog from zero.
        if (state_d != state_q) wd_d = '0;
    end

    assign state_o = state_q;

`ifdef NPC_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cyc_q, ir_q;
    logic                 active, retire;

    always_comb begin
        active = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
        // ebreak counts as retired when it lands in HALT.
        retire = (state_q == S_WB) || ((state_q == S_DECODE) && (state_d == S_HALT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ir_q  <= '0;
        end else begin
            if (active) cyc_q <= cyc_q + CNT_WIDTH'(1);
            if (retire) ir_q  <= ir_q + CNT_WIDTH'(1);
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ir_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Directed bench for npc_ctrl_fsm (TIMEOUT=4): per-cycle expected outputs go through a scoreboard queue.
module tb_npc_ctrl_fsm;

    localparam int CW = 64;

    logic clk = 1'b0;
    logic rst, start, if_ack, is_ebreak, is_illegal, is_mem, d_regW, mem_ack;
    logic if_req, inst_we, mem_req, w_regW, pc_we, halt, err;
    logic [2:0]    state_o;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    npc_ctrl_fsm #(.CNT_WIDTH(CW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .if_ack(if_ack),
        .is_ebreak(is_ebreak), .is_illegal(is_illegal), .is_mem(is_mem),
        .d_regW(d_regW), .mem_ack(mem_ack),
        .if_req(if_req), .inst_we(inst_we), .mem_req(mem_req), .w_regW(w_regW),
        .pc_we(pc_we), .halt(halt), .err(err), .state_o(state_o),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic [6:0]    strb;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ir;
    } obs_t;

    // strobe order: if_req inst_we mem_req w_regW pc_we halt err
    localparam logic [6:0] N   = 7'b0000000;
    localparam logic [6:0] IF  = 7'b1000000;
    localparam logic [6:0] IFA = 7'b1100000;
    localparam logic [6:0] MR  = 7'b0010000;
    localparam logic [6:0] WB1 = 7'b0001100;
    localparam logic [6:0] WB0 = 7'b0000100;
    localparam logic [6:0] HL  = 7'b0000010;
    localparam logic [6:0] ER  = 7'b0000001;

    obs_t          sb[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cyc = '0;
    logic [CW-1:0] exp_ir  = '0;

    task automatic cyc(input string tag, input logic r, s, ia, eb, il, im, rw, ma,
                       input logic [2:0] est, input logic [6:0] estb);
        obs_t e;
        logic [6:0] strb;
        rst = r; start = s; if_ack = ia; is_ebreak = eb; is_illegal = il;
        is_mem = im; d_regW = rw; mem_ack = ma;
        sb.push_back('{est, estb, exp_cyc, exp_ir});
        #2;
        e    = sb.pop_front();
        strb = {if_req, inst_we, mem_req, w_regW, pc_we, halt, err};
        n_cmp++;
        assert (state_o === e.st) else begin
            n_fail++; $error("FAIL %s state: observed %0d expected %0d", tag, state_o, e.st);
        end
        n_cmp++;
        assert (strb === e.strb) else begin
            n_fail++; $error("FAIL %s strobes: observed %b expected %b", tag, strb, e.strb);
        end
        n_cmp++;
        assert (cycle_cnt === e.cyc) else begin
            n_fail++; $error("FAIL %s cycle_cnt: observed %0d expected %0d", tag, cycle_cnt, e.cyc);
        end
        n_cmp++;
        assert (instret_cnt === e.ir) else begin
            n_fail++; $error("FAIL %s instret_cnt: observed %0d expected %0d", tag, instret_cnt, e.ir);
        end
        @(posedge clk);
        @(negedge clk);
`ifdef NPC_PERF_CNT_EN
        if (r) begin
            exp_cyc = '0;
            exp_ir  = '0;
        end else begin
            if (est != 3'd0 && est != 3'd6 && est != 3'd7) exp_cyc = exp_cyc + 1;
            if (est == 3'd5 || (est == 3'd2 && eb && !il)) exp_ir = exp_ir + 1;
        end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 0; if_ack = 0; is_ebreak = 0; is_illegal = 0;
        is_mem = 0; d_regW = 0; mem_ack = 0;
        @(posedge clk);
        @(negedge clk);
        //         tag      r  s ia eb il im rw ma  st  strobes
        cyc("reset",   0, 0, 0, 0, 0, 0, 0, 0, 3'd0, N);
        // ALU op, zero-wait fetch, writes rd
        cyc("start",   0, 1, 0, 0, 0, 0, 0, 0, 3'd0, N);
        cyc("alu_f",   0, 0, 1, 0, 0, 0, 0, 0, 3'd1, IFA);
        cyc("alu_d",   0, 0, 0, 0, 0, 0, 0, 0, 3'd2, N);
        cyc("alu_x",   0, 0, 0, 0, 0, 0, 0, 0, 3'd3, N);
        cyc("alu_wb",  0, 0, 0, 0, 0, 0, 1, 0, 3'd5, WB1);
        // load with 3 mem wait cycles; spurious mem_ack in FETCH ignored
        cyc("ld_f",    0, 0, 1, 0, 0, 0, 0, 1, 3'd1, IFA);
        cyc("ld_d",    0, 0, 0, 0, 0, 0, 0, 0, 3'd2, N);
        cyc("ld_x",    0, 0, 0, 0, 0, 1, 0, 0, 3'd3, N);
        cyc("ld_m0",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("ld_m1",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("ld_m2",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("ld_m3",   0, 0, 0, 0, 0, 0, 0, 1, 3'd4, MR);
        cyc("ld_wb",   0, 0, 0, 0, 0, 0, 1, 0, 3'd5, WB1);
        // ALU op without rd write
        cyc("nw_f",    0, 0, 1, 0, 0, 0, 0, 0, 3'd1, IFA);
        cyc("nw_d",    0, 0, 0, 0, 0, 0, 0, 0, 3'd2, N);
        cyc("nw_x",    0, 0, 0, 0, 0, 0, 0, 0, 3'd3, N);
        cyc("nw_wb",   0, 0, 0, 0, 0, 0, 0, 0, 3'd5, WB0);
        // fetch timeout: 4 FETCH cycles then ERR; illegal outside DECODE ignored
        cyc("to_f1",   0, 0, 0, 0, 1, 0, 0, 0, 3'd1, IF);
        cyc("to_f2",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, IF);
        cyc("to_f3",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, IF);
        cyc("to_f4",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, IF);
        cyc("to_err",  0, 1, 1, 0, 0, 0, 0, 1, 3'd7, ER);
        cyc("to_errs", 0, 0, 1, 0, 0, 0, 0, 0, 3'd7, ER);
        cyc("to_rst",  1, 0, 0, 0, 0, 0, 0, 0, 3'd7, ER);
        // ack on the 4th FETCH cycle wins, then ebreak halts
        cyc("ak_idle", 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, N);
        cyc("ak_f1",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, IF);
        cyc("ak_f2",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, IF);
        cyc("ak_f3",   0, 0, 0, 0, 0, 0, 0, 0, 3'd1, IF);
        cyc("ak_f4",   0, 0, 1, 0, 0, 0, 0, 0, 3'd1, IFA);
        cyc("eb_d",    0, 0, 0, 1, 0, 0, 0, 0, 3'd2, N);
        cyc("eb_h1",   0, 1, 1, 0, 0, 0, 0, 1, 3'd6, HL);
        cyc("eb_h2",   0, 1, 1, 1, 1, 1, 1, 1, 3'd6, HL);
        cyc("eb_h3",   0, 0, 0, 0, 0, 0, 0, 0, 3'd6, HL);
        cyc("eb_rst",  1, 0, 0, 0, 0, 0, 0, 0, 3'd6, HL);
        // illegal wins over ebreak
        cyc("il_idle", 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, N);
        cyc("il_f",    0, 0, 1, 0, 0, 0, 0, 0, 3'd1, IFA);
        cyc("il_d",    0, 0, 0, 1, 1, 0, 0, 0, 3'd2, N);
        cyc("il_err",  0, 1, 1, 1, 0, 0, 0, 0, 3'd7, ER);
        cyc("il_rst",  1, 0, 0, 0, 0, 0, 0, 0, 3'd7, ER);
        // reset while mem_req is high
        cyc("rm_idle", 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, N);
        cyc("rm_f",    0, 0, 1, 0, 0, 0, 0, 0, 3'd1, IFA);
        cyc("rm_d",    0, 0, 0, 0, 0, 0, 0, 0, 3'd2, N);
        cyc("rm_x",    0, 0, 0, 0, 0, 1, 0, 0, 3'd3, N);
        cyc("rm_m",    0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("rm_rst",  1, 0, 0, 0, 0, 0, 0, 1, 3'd4, MR);
        cyc("rm_post", 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, N);
        // memory timeout
        cyc("mt_idle", 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, N);
        cyc("mt_f",    0, 0, 1, 0, 0, 0, 0, 0, 3'd1, IFA);
        cyc("mt_d",    0, 0, 0, 0, 0, 0, 0, 0, 3'd2, N);
        cyc("mt_x",    0, 0, 0, 0, 0, 1, 0, 0, 3'd3, N);
        cyc("mt_m1",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("mt_m2",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("mt_m3",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("mt_m4",   0, 0, 0, 0, 0, 0, 0, 0, 3'd4, MR);
        cyc("mt_err",  0, 0, 0, 0, 0, 0, 0, 1, 3'd7, ER);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
